// File: rtl/galaga.sv
// galaga: per-pixel sprite compositor.
// For the current scan pixel, tests every active game object for a hit and
// registers one pixel-class code for the downstream colour stage.
//   i_Clk, i_Rst_n            pixel clock, async active-low reset
//   i_n_PixelPos_x/_y         current scan pixel
//   i_*State                  per-object alive/active bits
//   i_*Position               per-object {Y[19:10], X[9:0]} top-left corner
//   o_pixelState              registered class code (0 bg, 1 player, 2 enemy,
//                             3 player bullet, 4 enemy bullet)
module galaga #(
    parameter int unsigned N_ENEMY   = 8,
    parameter int unsigned N_EBULLET = 4,
    parameter int unsigned N_PBULLET = 4,
    parameter int unsigned SPRITE_W  = 16,
    parameter int unsigned SPRITE_H  = 16,
    parameter int unsigned BULLET_W  = 2,
    parameter int unsigned BULLET_H  = 6,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic [9:0]                i_n_PixelPos_x,
    input  logic [9:0]                i_n_PixelPos_y,
    input  logic [N_ENEMY-1:0]        i_enemyState,
    input  logic [20*N_ENEMY-1:0]     i_enemyPosition,
    input  logic [N_EBULLET-1:0]      i_enemyBulletState,
    input  logic [20*N_EBULLET-1:0]   i_enemyBulletPosition,
    input  logic                      i_playerState,
    input  logic [19:0]               i_playerPosition,
    input  logic [N_PBULLET-1:0]      i_playerBulletState,
    input  logic [20*N_PBULLET-1:0]   i_playerBulletPosition,
    output logic [2:0]                o_pixelState
);

    localparam int unsigned POS_W  = 20;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned EXT_W  = 11;

    localparam logic [CODE_W-1:0] CODE_BG      = 3'd0;
    localparam logic [CODE_W-1:0] CODE_PLAYER  = 3'd1;
    localparam logic [CODE_W-1:0] CODE_ENEMY   = 3'd2;
    localparam logic [CODE_W-1:0] CODE_PBULLET = 3'd3;
    localparam logic [CODE_W-1:0] CODE_EBULLET = 3'd4;

    localparam logic [EXT_W-1:0] SPR_W_X = EXT_W'(SPRITE_W);
    localparam logic [EXT_W-1:0] SPR_H_X = EXT_W'(SPRITE_H);
    localparam logic [EXT_W-1:0] BUL_W_X = EXT_W'(BULLET_W);
    localparam logic [EXT_W-1:0] BUL_H_X = EXT_W'(BULLET_H);
    localparam logic [EXT_W-1:0] H_ACT_X = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0] V_ACT_X = EXT_W'(V_ACTIVE);

    // Rectangle hit test; edges are summed at 11 bits so objects near 1023 never wrap.
    function automatic logic hit(
        input logic [9:0]       px,
        input logic [9:0]       py,
        input logic [POS_W-1:0] pos,
        input logic [EXT_W-1:0] w,
        input logic [EXT_W-1:0] h
    );
        logic [EXT_W-1:0] ox;
        logic [EXT_W-1:0] oy;
        logic [EXT_W-1:0] pxe;
        logic [EXT_W-1:0] pye;
        ox  = {1'b0, pos[9:0]};
        oy  = {1'b0, pos[19:10]};
        pxe = {1'b0, px};
        pye = {1'b0, py};
        return (pxe >= ox) && (pxe < ox + w) && (pye >= oy) && (pye < oy + h);
    endfunction

    logic              pb_hit_c;
    logic              eb_hit_c;
    logic              pl_hit_c;
    logic              en_hit_c;
    logic              active_c;
    logic [CODE_W-1:0] pixel_d;
    logic [CODE_W-1:0] pixel_q;

    // Per-class hit reduction over all active objects.
    always_comb begin
        pb_hit_c = 1'b0;
        eb_hit_c = 1'b0;
        en_hit_c = 1'b0;
        for (int k = 0; k < int'(N_PBULLET); k++) begin
            if (i_playerBulletState[k] &&
                hit(i_n_PixelPos_x, i_n_PixelPos_y,
                    i_playerBulletPosition[POS_W*k +: POS_W], BUL_W_X, BUL_H_X))
                pb_hit_c = 1'b1;
        end
        for (int k = 0; k < int'(N_EBULLET); k++) begin
            if (i_enemyBulletState[k] &&
                hit(i_n_PixelPos_x, i_n_PixelPos_y,
                    i_enemyBulletPosition[POS_W*k +: POS_W], BUL_W_X, BUL_H_X))
                eb_hit_c = 1'b1;
        end
        for (int k = 0; k < int'(N_ENEMY); k++) begin
            if (i_enemyState[k] &&
                hit(i_n_PixelPos_x, i_n_PixelPos_y,
                    i_enemyPosition[POS_W*k +: POS_W], SPR_W_X, SPR_H_X))
                en_hit_c = 1'b1;
        end
        pl_hit_c = i_playerState &&
                   hit(i_n_PixelPos_x, i_n_PixelPos_y, i_playerPosition, SPR_W_X, SPR_H_X);
    end

    // Active-area gate and fixed class priority.
    always_comb begin
        pixel_d  = CODE_BG;
        active_c = ({1'b0, i_n_PixelPos_x} < H_ACT_X) && ({1'b0, i_n_PixelPos_y} < V_ACT_X);
        if (active_c) begin
            if (pb_hit_c)      pixel_d = CODE_PBULLET;
            else if (eb_hit_c) pixel_d = CODE_EBULLET;
            else if (pl_hit_c) pixel_d = CODE_PLAYER;
            else if (en_hit_c) pixel_d = CODE_ENEMY;
        end
    end

    // Output register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) pixel_q <= CODE_BG;
        else          pixel_q <= pixel_d;
    end

    assign o_pixelState = pixel_q;

endmodule

// File: tb/tb_galaga.sv
// tb_galaga: directed and randomized checks of the galaga pixel compositor
// against a rectangle-geometry model of the scene.
module tb_galaga;

    localparam int NE = 8;
    localparam int NEB = 4;
    localparam int NPB = 4;

    logic              clk;
    logic              rst_n;
    logic [9:0]        px;
    logic [9:0]        py;
    logic [NE-1:0]     en_st;
    logic [20*NE-1:0]  en_pos;
    logic [NEB-1:0]    eb_st;
    logic [20*NEB-1:0] eb_pos;
    logic              pl_st;
    logic [19:0]       pl_pos;
    logic [NPB-1:0]    pb_st;
    logic [20*NPB-1:0] pb_pos;
    logic [2:0]        pix;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    logic [2:0] exp_q;

    galaga dut (
        .i_Clk                  (clk),
        .i_Rst_n                (rst_n),
        .i_n_PixelPos_x         (px),
        .i_n_PixelPos_y         (py),
        .i_enemyState           (en_st),
        .i_enemyPosition        (en_pos),
        .i_enemyBulletState     (eb_st),
        .i_enemyBulletPosition  (eb_pos),
        .i_playerState          (pl_st),
        .i_playerPosition       (pl_pos),
        .i_playerBulletState    (pb_st),
        .i_playerBulletPosition (pb_pos),
        .o_pixelState           (pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] pk(input int x, input int y);
        return {10'(y), 10'(x)};
    endfunction

    function automatic bit inside_rect(input int qx, input int qy, input int x, input int y,
                                       input int w, input int h);
        return qx >= x && qx < x + w && qy >= y && qy < y + h;
    endfunction

    // Scene model: integer geometry, then class priority.
    function automatic logic [2:0] model();
        int  qx;
        int  qy;
        bit  pb;
        bit  eb;
        bit  pl;
        bit  en;
        qx = int'(px);
        qy = int'(py);
        pb = 0; eb = 0; en = 0;
        if (qx >= 640 || qy >= 480) return 3'd0;
        for (int k = 0; k < NPB; k++)
            if (pb_st[k] && inside_rect(qx, qy, int'(pb_pos[20*k +: 10]),
                                        int'(pb_pos[20*k+10 +: 10]), 2, 6)) pb = 1;
        for (int k = 0; k < NEB; k++)
            if (eb_st[k] && inside_rect(qx, qy, int'(eb_pos[20*k +: 10]),
                                        int'(eb_pos[20*k+10 +: 10]), 2, 6)) eb = 1;
        for (int k = 0; k < NE; k++)
            if (en_st[k] && inside_rect(qx, qy, int'(en_pos[20*k +: 10]),
                                        int'(en_pos[20*k+10 +: 10]), 16, 16)) en = 1;
        pl = pl_st && inside_rect(qx, qy, int'(pl_pos[9:0]), int'(pl_pos[19:10]), 16, 16);
        if (pb) return 3'd3;
        if (eb) return 3'd4;
        if (pl) return 3'd1;
        if (en) return 3'd2;
        return 3'd0;
    endfunction

    // Expected output: model of the inputs seen at each rising edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 3'd0;
        else        exp_q <= model();
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (pix !== exp_q) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t px=%0d py=%0d got=%0d want=%0d",
                         $time, px, py, pix, exp_q);
            end
        end
    end

    task automatic check_lit(input string name, input logic [2:0] want);
        n_tests++;
        if (pix !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, pix, want);
        end
    endtask

    task automatic clear_scene();
        en_st = '0; en_pos = '0; eb_st = '0; eb_pos = '0;
        pl_st = 1'b0; pl_pos = '0; pb_st = '0; pb_pos = '0;
    endtask

    // Apply a pixel, let one edge register it, then check a literal code.
    task automatic step(input int x, input int y, input logic [2:0] want, input string name);
        px = 10'(x);
        py = 10'(y);
        @(posedge clk); #2;
        check_lit(name, want);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_scene();
        pl_st = 1'b1; pl_pos = pk(100, 200);
        px = 10'd105; py = 10'd205;
        repeat (3) @(posedge clk);
        #2 check_lit("reset_hold", 3'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #2;
        check_lit("reset_release", 3'd1);

        step(100, 200, 3'd1, "pl_topleft");
        step(115, 215, 3'd1, "pl_botright");
        step(116, 200, 3'd0, "pl_right_out");
        step(99, 200, 3'd0, "pl_left_out");

        // Output lags the pixel by one clock.
        px = 10'd99;
        @(posedge clk); #2;
        px = 10'd100;
        check_lit("lag_old", 3'd0);
        @(posedge clk); #2;
        check_lit("lag_new", 3'd1);

        clear_scene();
        en_pos[20*3 +: 20] = pk(300, 50);
        en_st = 8'b0000_1000;
        step(310, 60, 3'd2, "enemy_alive");
        en_st = 8'b0;
        step(310, 60, 3'd0, "enemy_dead");

        clear_scene();
        pl_st = 1'b1; pl_pos = pk(100, 200);
        pb_pos[19:0] = pk(104, 202); pb_st = 4'b0001;
        eb_pos[20 +: 20] = pk(104, 202); eb_st = 4'b0010;
        step(105, 203, 3'd3, "prio_all");
        pb_st = 4'b0;
        step(105, 203, 3'd4, "prio_eb");
        eb_st = 4'b0;
        step(105, 203, 3'd1, "prio_player");

        clear_scene();
        en_pos[19:0] = pk(1020, 1020); en_st = 8'b1;
        step(1023, 1023, 3'd0, "offscreen");
        step(3, 3, 3'd0, "no_wrap");
        en_pos[19:0] = pk(630, 470);
        step(639, 479, 3'd2, "edge_in");
        step(640, 479, 3'd0, "edge_clip");

        clear_scene();
        eb_pos[19:0] = pk(200, 100); eb_st = 4'b1;
        step(201, 105, 3'd4, "bullet_in");
        step(202, 105, 3'd0, "bullet_w");
        step(201, 106, 3'd0, "bullet_h");

        // Randomized scenes clustered around the pixel so hits are frequent.
        for (int c = 0; c < 3000; c++) begin
            int bx;
            int by;
            bx = int'($urandom_range(0, 1023));
            by = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                bx = int'($urandom_range(0, 660));
                by = int'($urandom_range(0, 500));
            end
            px = 10'(bx); py = 10'(by);
            en_st = 8'($urandom); eb_st = 4'($urandom); pb_st = 4'($urandom);
            pl_st = 1'($urandom);
            for (int k = 0; k < NE; k++)
                en_pos[20*k +: 20] = pk(bx - int'($urandom_range(0, 20)), by - int'($urandom_range(0, 20)));
            for (int k = 0; k < NEB; k++)
                eb_pos[20*k +: 20] = pk(bx - int'($urandom_range(0, 3)), by - int'($urandom_range(0, 8)));
            for (int k = 0; k < NPB; k++)
                pb_pos[20*k +: 20] = pk(bx - int'($urandom_range(0, 3)), by - int'($urandom_range(0, 8)));
            pl_pos = pk(bx - int'($urandom_range(0, 20)), by - int'($urandom_range(0, 20)));
            if (c == 1500) begin
                rst_n = 1'b0;
                #1;
                check_lit("async_reset", 3'd0);
                @(posedge clk); #2;
                rst_n = 1'b1;
            end
            @(posedge clk); #2;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/galaga.md
Name: galaga

Overview:
- Per-pixel sprite compositor for the Galaga monitor demo.
- Each clock it takes the current scan pixel coordinate plus the state and position of every game object. It outputs one registered pixel-class code.
- A downstream colour stage maps that code to the RGB, hSync and vSync outputs.
- Sits between the game-logic blocks (object state and positions) and the VGA timing/colour block.

Parameters:
- N_ENEMY, 8, number of enemy sprites
- N_EBULLET, 4, number of enemy bullets
- N_PBULLET, 4, number of player bullets
- SPRITE_W, 16, enemy/player sprite width in pixels
- SPRITE_H, 16, enemy/player sprite height in pixels
- BULLET_W, 2, bullet width in pixels
- BULLET_H, 6, bullet height in pixels
- H_ACTIVE, 640, visible width
- V_ACTIVE, 480, visible height

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_n_PixelPos_x  in  10  current pixel X
- i_n_PixelPos_y  in  10  current pixel Y
- i_enemyState  in  N_ENEMY  bit k=1: enemy k alive
- i_enemyPosition  in  20*N_ENEMY  enemy k at [20k+19:20k]; {Y[19:10], X[9:0]}; top-left corner
- i_enemyBulletState  in  N_EBULLET  bit k=1: enemy bullet k active
- i_enemyBulletPosition  in  20*N_EBULLET  same packing as enemies
- i_playerState  in  1  1 = player alive
- i_playerPosition  in  20  {Y, X}, top-left corner
- i_playerBulletState  in  N_PBULLET  bit k=1: player bullet k active
- i_playerBulletPosition  in  20*N_PBULLET  same packing
- o_pixelState  out  3  pixel class code

Behaviour:
- Codes:
  - 0 = background
  - 1 = player
  - 2 = enemy
  - 3 = player bullet
  - 4 = enemy bullet
  - 5–7 unused, never driven
- Hit test for an object at (X,Y) with size (W,H):
  - Hit when px >= X, px < X+W, py >= Y and py < Y+H.
  - Sums are computed at 11 bits, so an object near coordinate 1023 never wraps to 0.
- An object participates only when its state bit is 1; an inactive object never hits regardless of its position.
- Priority, highest first: player bullet (3) > enemy bullet (4) > player (1) > enemy (2) > background (0).
- Multiple hits of the same class give the same code; index order is irrelevant.
- Pixels with px >= H_ACTIVE or py >= V_ACTIVE give code 0, even when an object overlaps them.
- Timing:
  - Hit tests are purely combinational.
  - o_pixelState is registered on the rising edge of i_Clk, so latency is exactly 1 cycle from input to output.
- Reset:
  - i_Rst_n=0 asynchronously forces o_pixelState=0.
  - While reset is held, the output stays 0.
  - The first rising edge after release registers the current inputs.
- Inputs are sampled every cycle; there is no handshake and no internal state beyond the output register.
- Objects placed partly offscreen are clipped naturally by the active-area rule.

Test Plan:
- Reset: hold i_Rst_n=0 with player alive at (100,200) and pixel (105,205) → o_pixelState=0. Release; one clock later → 1.
- Player boundaries, player at (100,200):
  - pixel (100,200) → 1
  - pixel (115,215) → 1
  - pixel (116,200) → 0
  - pixel (99,200) → 0
  - Output lags the pixel inputs by one clock.
- Enemy with state gating: enemy 3 at (300,50), i_enemyState=8'b0000_1000, pixel (310,60) → 2. Same with i_enemyState=0 → 0.
- Priority overlap: player at (100,200), player bullet 0 at (104,202) active, enemy bullet 1 at (104,202) active, pixel (105,203):
  - all three active → 3
  - player bullet off → 4
  - both bullets off → 1
- Active-area clip and wrap: enemy 0 at (1020,1020) alive:
  - pixel (1023,1023) → 0
  - pixel (3,3) → 0 (no wraparound)
  - enemy at (630,470), pixel (639,479) → 2
  - pixel (640,479) → 0
- Bullet size: enemy bullet 0 at (200,100):
  - pixel (201,105) → 4
  - pixel (202,105) → 0
  - pixel (201,106) → 0
